color_detector: RTL and testbench
=================================

Name: color_detector

Overview:
- Consumes the RGB332 pixel stream produced by the camera capture stage (pixel colour, write-enable, X/Y coordinates) together with the camera VSYNC.
- Counts red-classified and blue-classified pixels within a rectangular region of interest (ROI) over one frame.
- At end of frame, reports the dominant colour (none/red/blue) to the robot controller with a one-cycle valid pulse.
- Inputs are already re-registered into the CLK domain upstream; this block sees one synchronous stream.

Parameters:
- ROI_X_MIN, 0, first column counted (inclusive)
- ROI_X_MAX, 175, last column counted (inclusive)
- ROI_Y_MIN, 0, first row counted (inclusive)
- ROI_Y_MAX, 143, last row counted (inclusive)
- RED_R_MIN, 4, minimum R field (3-bit) for a red pixel
- BLUE_B_MIN, 2, minimum B field (2-bit) for a blue pixel
- COUNT_THRESH, 1000, minimum pixel count required to declare a colour

Ports:
- CLK  input  1  system clock
- RST_N  input  1  synchronous active-low reset
- PIXEL_COLOR  input  8  RGB332: R=[7:5], G=[4:2], B=[1:0]
- PIXEL_VALID  input  1  pixel strobe, one pixel per high cycle
- X  input  10  pixel column
- Y  input  10  pixel row
- VSYNC  input  1  high = vertical blanking; falling edge = frame start, rising edge = frame end
- RESULT  output  2  00 none, 01 red, 10 blue (11 never driven)
- RESULT_VALID  output  1  one-cycle pulse when RESULT updates
- RED_COUNT  output  15  red count of last completed frame
- BLUE_COUNT  output  15  blue count of last completed frame

Behaviour:
- One clock; reset is synchronous and active-low. Clock port CLK, reset port RST_N.
- Reset (RST_N=0 at a CLK edge): RESULT=00, RESULT_VALID=0, RED_COUNT=0, BLUE_COUNT=0, internal counters=0, state=IDLE, registered VSYNC copy=1.
- Edge detect: vsync_q is VSYNC registered once.
  - fall = vsync_q & ~VSYNC
  - rise = ~vsync_q & VSYNC
- Pixel classification (combinational on PIXEL_COLOR):
  - red: R>=RED_R_MIN and G<=2 and B<=1
  - blue: B>=BLUE_B_MIN and R<=2 and G<=3
  - Red and blue are mutually exclusive under the defaults.
- A pixel is counted only when all hold: state=ACCUM, PIXEL_VALID=1, VSYNC=0, and X/Y inside the ROI (inclusive bounds).
- Counters are 15 bits and saturate at 32767; they never wrap.
- States:
  - IDLE: wait for fall; on fall, clear both counters and go to ACCUM. A rise seen in IDLE is ignored; no report is made for a partial frame after reset.
  - ACCUM: count pixels. On rise go to DECIDE. A pixel strobe in the same cycle as rise is not counted, because VSYNC=1.
  - DECIDE (1 cycle): latch counters into RED_COUNT/BLUE_COUNT and compute the colour:
    - red if red>=COUNT_THRESH and red>blue
    - else blue if blue>=COUNT_THRESH and blue>red
    - else none (this includes ties)
  - REPORT (1 cycle): drive RESULT, pulse RESULT_VALID=1, go to IDLE.
- Latency: RESULT_VALID asserts 3 CLK cycles after the cycle in which VSYNC is first sampled high (edge register, DECIDE, REPORT).
- RESULT, RED_COUNT and BLUE_COUNT hold their values until the next REPORT.
- A fall that arrives while in DECIDE or REPORT is missed; that frame is skipped and detection resumes on the next fall. Upstream guarantees blanking of at least 4 cycles, so this does not occur in normal operation.
- Reset mid-frame: all state clears immediately and the block waits for a fresh fall.

Decomposition:
- Shared package holds:
  - RESULT encodings: COLOR_NONE=2'b00, COLOR_RED=2'b01, COLOR_BLUE=2'b10
  - state encodings: IDLE, ACCUM, DECIDE, REPORT
  - RGB332 field bit positions
- One natural sub-module: pixel_classifier, purely combinational, PIXEL_COLOR -> {is_red, is_blue}, parameterised by RED_R_MIN and BLUE_B_MIN. Unit-test it separately.

Test Plan:
- Full frame of 0xE0 (R=7, G=0, B=0), 176x144 valid pixels -> RED_COUNT=25344, BLUE_COUNT=0, RESULT=01, RESULT_VALID high for exactly 1 cycle, 3 cycles after VSYNC rises.
- Frame with 1200 pixels of 0x03 and 800 of 0xE0, rest 0x1C -> BLUE_COUNT=1200, RED_COUNT=800, RESULT=10.
- Frame with 1500 red and 1500 blue (tie); then a frame with 999 red and 0 blue -> RESULT=00 both times, counts reported exactly.
- Red pixels only at X=176..200 or Y=150, plus PIXEL_VALID pulses while VSYNC=1 -> RED_COUNT=0, RESULT=00.
- RST_N low for 1 cycle mid-frame after 2000 red pixels; VSYNC then rises without a new fall -> no RESULT_VALID, outputs stay 0. The next full red frame reports RESULT=01.
- Counter saturation (ROI_X_MAX=1023, ROI_Y_MAX=1023): 40000 red pixels -> RED_COUNT=32767, RESULT=01.

Source files
------------

// File: rtl/color_detector_pkg.sv
// Shared encodings and helpers for the colour detector.
// Holds result codes, FSM states, RGB332 field positions and counter width.
// Also holds a saturating-increment helper used by the pixel counters.
package color_detector_pkg;

  typedef enum logic [1:0] {
    COLOR_NONE = 2'b00,
    COLOR_RED  = 2'b01,
    COLOR_BLUE = 2'b10
  } color_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCUM  = 2'b01,
    DECIDE = 2'b10,
    REPORT = 2'b11
  } state_e;

  // RGB332 field positions
  localparam int R_HI = 7;
  localparam int R_LO = 5;
  localparam int G_HI = 4;
  localparam int G_LO = 2;
  localparam int B_HI = 1;
  localparam int B_LO = 0;

  localparam int               CNT_W   = 15;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Increment that sticks at the top value instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/color_detector_pixel_classifier.sv
// Classifies one RGB332 pixel as red, blue or neither.
// Latency: purely combinational.
// Backpressure: none; output follows input every cycle.
module color_detector_pixel_classifier
  import color_detector_pkg::*;
#(
  parameter int RED_R_MIN  = 4,
  parameter int BLUE_B_MIN = 2
) (
  input  logic [7:0] pixel_color_i,
  output logic       is_red_o,
  output logic       is_blue_o
);

  logic [2:0] r_fld;
  logic [2:0] g_fld;
  logic [1:0] b_fld;

  assign r_fld = pixel_color_i[R_HI:R_LO];
  assign g_fld = pixel_color_i[G_HI:G_LO];
  assign b_fld = pixel_color_i[B_HI:B_LO];

  // Red needs a strong R with little green/blue; blue the mirror image
  always_comb begin
    is_red_o  = (r_fld >= 3'(RED_R_MIN)) && (g_fld <= 3'd2) && (b_fld <= 2'd1);
    is_blue_o = (b_fld >= 2'(BLUE_B_MIN)) && (r_fld <= 3'd2) && (g_fld <= 3'd3);
  end

endmodule

// File: rtl/color_detector.sv
// Counts red/blue pixels in an ROI per frame and reports the dominant colour.
// Latency: RESULT_VALID pulses 3 cycles after VSYNC is first sampled high.
// Backpressure: none; the pixel stream is consumed unconditionally.
module color_detector
  import color_detector_pkg::*;
#(
  parameter int ROI_X_MIN    = 0,
  parameter int ROI_X_MAX    = 175,
  parameter int ROI_Y_MIN    = 0,
  parameter int ROI_Y_MAX    = 143,
  parameter int RED_R_MIN    = 4,
  parameter int BLUE_B_MIN   = 2,
  parameter int COUNT_THRESH = 1000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [7:0]  PIXEL_COLOR,
  input  logic        PIXEL_VALID,
  input  logic [9:0]  X,
  input  logic [9:0]  Y,
  input  logic        VSYNC,
  output logic [1:0]  RESULT,
  output logic        RESULT_VALID,
  output logic [14:0] RED_COUNT,
  output logic [14:0] BLUE_COUNT
);

  state_e           state_q, state_d;
  logic             vsync_q;
  logic             blank_seen_q;
  logic [CNT_W-1:0] red_cnt_q, blue_cnt_q;
  logic [CNT_W-1:0] red_count_q, blue_count_q;
  color_e           color_q, color_d;
  logic [1:0]       result_q;
  logic             result_valid_q;

  logic is_red, is_blue;
  logic fall, rise, in_roi, count_en;

  color_detector_pixel_classifier #(
    .RED_R_MIN (RED_R_MIN),
    .BLUE_B_MIN(BLUE_B_MIN)
  ) u_classifier (
    .pixel_color_i(PIXEL_COLOR),
    .is_red_o     (is_red),
    .is_blue_o    (is_blue)
  );

  // A fall only counts once real blanking has been seen since reset, so a
  // reset in mid-frame cannot start a partial frame.
  assign fall = vsync_q & ~VSYNC & blank_seen_q;
  assign rise = ~vsync_q & VSYNC;

  assign in_roi = (int'(X) >= ROI_X_MIN) && (int'(X) <= ROI_X_MAX) &&
                  (int'(Y) >= ROI_Y_MIN) && (int'(Y) <= ROI_Y_MAX);
  assign count_en = (state_q == ACCUM) && PIXEL_VALID && !VSYNC && in_roi;

  // VSYNC edge-detect register and blanking-seen flag
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      vsync_q      <= 1'b1;
      blank_seen_q <= 1'b0;
    end else begin
      vsync_q      <= VSYNC;
      blank_seen_q <= blank_seen_q | VSYNC;
    end
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: frame start, frame end, then one decide and one report cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fall) state_d = ACCUM;
      ACCUM:   if (rise) state_d = DECIDE;
      DECIDE:  state_d = REPORT;
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Per-frame saturating pixel counters, cleared at frame start
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      red_cnt_q  <= '0;
      blue_cnt_q <= '0;
    end else if ((state_q == IDLE) && fall) begin
      red_cnt_q  <= '0;
      blue_cnt_q <= '0;
    end else if (count_en) begin
      if (is_red)  red_cnt_q  <= sat_inc(red_cnt_q);
      if (is_blue) blue_cnt_q <= sat_inc(blue_cnt_q);
    end
  end

  // Dominant colour: must reach threshold and strictly beat the other; ties give none
  always_comb begin
    color_d = COLOR_NONE;
    if ((int'(red_cnt_q) >= COUNT_THRESH) && (red_cnt_q > blue_cnt_q))
      color_d = COLOR_RED;
    else if ((int'(blue_cnt_q) >= COUNT_THRESH) && (blue_cnt_q > red_cnt_q))
      color_d = COLOR_BLUE;
  end

  // DECIDE latches counts and decision; REPORT publishes result with a valid pulse
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      red_count_q    <= '0;
      blue_count_q   <= '0;
      color_q        <= COLOR_NONE;
      result_q       <= COLOR_NONE;
      result_valid_q <= 1'b0;
    end else begin
      result_valid_q <= (state_q == REPORT);
      if (state_q == DECIDE) begin
        red_count_q  <= red_cnt_q;
        blue_count_q <= blue_cnt_q;
        color_q      <= color_d;
      end
      if (state_q == REPORT) result_q <= color_q;
    end
  end

  assign RESULT       = result_q;
  assign RESULT_VALID = result_valid_q;
  assign RED_COUNT    = red_count_q;
  assign BLUE_COUNT   = blue_count_q;

endmodule

// File: tb/tb_color_detector.sv
// Self-checking bench for color_detector and its pixel classifier.
// Uses a behavioural pixel-count model and directed plus random frames.
// Second instance has a huge ROI so counter saturation can be observed.
module tb_color_detector;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [7:0]  PIXEL_COLOR;
  logic        PIXEL_VALID;
  logic [9:0]  X, Y;
  logic        VSYNC;
  logic [1:0]  RESULT, big_result;
  logic        RESULT_VALID, big_valid;
  logic [14:0] RED_COUNT, BLUE_COUNT, big_red, big_blue;

  logic [7:0]  cls_in;
  logic        cls_red, cls_blue;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  int m_red[2];
  int m_blue[2];
  int roi_xmax[2] = '{175, 1023};
  int roi_ymax[2] = '{143, 1023};

  always #5 CLK = ~CLK;

  color_detector dut (
    .CLK(CLK), .RST_N(RST_N), .PIXEL_COLOR(PIXEL_COLOR), .PIXEL_VALID(PIXEL_VALID),
    .X(X), .Y(Y), .VSYNC(VSYNC), .RESULT(RESULT), .RESULT_VALID(RESULT_VALID),
    .RED_COUNT(RED_COUNT), .BLUE_COUNT(BLUE_COUNT)
  );

  color_detector #(.ROI_X_MAX(1023), .ROI_Y_MAX(1023)) dut_big (
    .CLK(CLK), .RST_N(RST_N), .PIXEL_COLOR(PIXEL_COLOR), .PIXEL_VALID(PIXEL_VALID),
    .X(X), .Y(Y), .VSYNC(VSYNC), .RESULT(big_result), .RESULT_VALID(big_valid),
    .RED_COUNT(big_red), .BLUE_COUNT(big_blue)
  );

  color_detector_pixel_classifier u_cls (
    .pixel_color_i(cls_in), .is_red_o(cls_red), .is_blue_o(cls_blue)
  );

  always @(negedge CLK) if (RESULT_VALID === 1'b1) pulses <= pulses + 1;

  function automatic bit ref_red(input logic [7:0] c);
    int r, g, b;
    r = int'(c) / 32; g = (int'(c) / 4) % 8; b = int'(c) % 4;
    return (r >= 4) && (g <= 2) && (b <= 1);
  endfunction

  function automatic bit ref_blue(input logic [7:0] c);
    int r, g, b;
    r = int'(c) / 32; g = (int'(c) / 4) % 8; b = int'(c) % 4;
    return (b >= 2) && (r <= 2) && (g <= 3);
  endfunction

  function automatic int ref_decide(input int r, input int b);
    if (r >= 1000 && r > b) return 1;
    if (b >= 1000 && b > r) return 2;
    return 0;
  endfunction

  function automatic int sat(input int v);
    return (v > 32767) ? 32767 : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK); #1;
  endtask

  // One pixel cycle inside a frame; model counts it if it qualifies
  task automatic pix(input logic [7:0] c, input int x, input int y, input bit v);
    PIXEL_COLOR = c; X = 10'(x); Y = 10'(y); PIXEL_VALID = v; VSYNC = 1'b0;
    if (v) begin
      for (int k = 0; k < 2; k++) begin
        if (x <= roi_xmax[k] && y <= roi_ymax[k]) begin
          if (ref_red(c))  m_red[k]  = sat(m_red[k] + 1);
          if (ref_blue(c)) m_blue[k] = sat(m_blue[k] + 1);
        end
      end
    end
    step();
  endtask

  // Blanking with stray red strobes, then the falling edge
  task automatic begin_frame();
    VSYNC = 1'b1; PIXEL_VALID = 1'b1; PIXEL_COLOR = 8'hE0; X = '0; Y = '0;
    repeat (3) step();
    VSYNC = 1'b0; PIXEL_VALID = 1'b0;
    step();
    for (int k = 0; k < 2; k++) begin m_red[k] = 0; m_blue[k] = 0; end
  endtask

  // Rising edge (with a strobe in the rise cycle) and report checks
  task automatic end_frame(input string tag, input bit chk_big);
    int p0;
    VSYNC = 1'b1; PIXEL_VALID = 1'b1; PIXEL_COLOR = 8'hE0; X = '0; Y = '0;
    p0 = pulses;
    step(); chk({tag, "_valid_c1"}, RESULT_VALID, 0);
    step(); chk({tag, "_valid_c2"}, RESULT_VALID, 0);
    step();
    chk({tag, "_valid_c3"}, RESULT_VALID, 1);
    chk({tag, "_red"},  RED_COUNT,  m_red[0]);
    chk({tag, "_blue"}, BLUE_COUNT, m_blue[0]);
    chk({tag, "_result"}, RESULT, ref_decide(m_red[0], m_blue[0]));
    if (chk_big) begin
      chk({tag, "_big_valid"}, big_valid, 1);
      chk({tag, "_big_red"}, big_red, m_red[1]);
      chk({tag, "_big_result"}, big_result, ref_decide(m_red[1], m_blue[1]));
    end
    step(); chk({tag, "_valid_c4"}, RESULT_VALID, 0);
    step(); chk({tag, "_pulse_count"}, pulses - p0, 1);
  endtask

  initial begin
    int x, y, j, sel, bias;
    logic [7:0] c;

    // Classifier unit test over every code
    for (int i = 0; i < 256; i++) begin
      cls_in = 8'(i);
      #1;
      chk("cls_red", cls_red, ref_red(8'(i)));
      chk("cls_blue", cls_blue, ref_blue(8'(i)));
    end

    // Reset
    RST_N = 1'b0; VSYNC = 1'b1; PIXEL_VALID = 1'b0; PIXEL_COLOR = '0; X = '0; Y = '0;
    repeat (3) step();
    chk("rst_result", RESULT, 0);
    chk("rst_valid", RESULT_VALID, 0);
    chk("rst_red", RED_COUNT, 0);
    chk("rst_blue", BLUE_COUNT, 0);
    RST_N = 1'b1;

    // Full 176x144 red frame, then red outside default ROI for saturation in dut_big
    begin_frame();
    for (int i = 0; i < 40000; i++) begin
      if (i < 25344) begin x = i % 176; y = i / 176; end
      else begin j = i - 25344; x = 176 + j % 800; y = j / 800; end
      pix(8'hE0, x, y, 1'b1);
    end
    end_frame("full", 1'b1);

    // 1200 blue, 800 red, 100 green
    begin_frame();
    for (int i = 0; i < 2100; i++) begin
      sel = i % 21;
      c = (sel < 12) ? 8'h03 : (sel < 20) ? 8'hE0 : 8'h1C;
      pix(c, i % 176, i / 176, 1'b1);
    end
    end_frame("mix", 1'b0);

    // Tie, then just below threshold
    begin_frame();
    for (int i = 0; i < 3000; i++) pix((i < 1500) ? 8'hE0 : 8'h03, i % 176, i / 176, 1'b1);
    end_frame("tie", 1'b0);
    begin_frame();
    for (int i = 0; i < 999; i++) pix(8'hE0, i % 176, i / 176, 1'b1);
    end_frame("thresh", 1'b0);

    // Red only just outside the ROI
    begin_frame();
    for (int i = 176; i <= 200; i++) pix(8'hE0, i, 0, 1'b1);
    for (int i = 0; i < 25; i++) pix(8'hE0, i, 150, 1'b1);
    end_frame("roi", 1'b1);

    // Reset mid-frame: the rest of that frame must not be reported
    begin_frame();
    for (int i = 0; i < 2000; i++) pix(8'hE0, i % 176, i / 176, 1'b1);
    RST_N = 1'b0; PIXEL_VALID = 1'b0;
    step();
    RST_N = 1'b1;
    chk("midrst_red", RED_COUNT, 0);
    chk("midrst_result", RESULT, 0);
    for (int i = 0; i < 10; i++) pix(8'hE0, i, 20, 1'b1);
    j = pulses;
    VSYNC = 1'b1; PIXEL_VALID = 1'b0;
    repeat (6) step();
    chk("midrst_no_pulse", pulses - j, 0);
    chk("midrst_result2", RESULT, 0);
    chk("midrst_red2", RED_COUNT, 0);
    chk("midrst_blue2", BLUE_COUNT, 0);
    begin_frame();
    for (int i = 0; i < 1100; i++) pix(8'hE0, i % 176, i / 176, 1'b1);
    end_frame("after_rst", 1'b0);

    // Random frames biased towards red, then blue
    for (int f = 0; f < 2; f++) begin
      begin_frame();
      for (int i = 0; i < 3000; i++) begin
        sel = int'($urandom_range(0, 9));
        bias = (sel < 7) ? f : (sel < 9) ? 1 - f : 2;
        if (bias == 0)
          c = {3'($urandom_range(4, 7)), 3'($urandom_range(0, 2)), 2'($urandom_range(0, 1))};
        else if (bias == 1)
          c = {3'($urandom_range(0, 2)), 3'($urandom_range(0, 3)), 2'($urandom_range(2, 3))};
        else
          c = 8'($urandom);
        pix(c, int'($urandom_range(0, 199)), int'($urandom_range(0, 159)),
            $urandom_range(0, 9) != 0);
      end
      end_frame((f == 0) ? "rand_red" : "rand_blue", 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
